// File: rtl/ao_register_file_pkg.sv
// Shared encodings, FSM state type and the size-merge helper for the
// ao68000 register file.
package ao68000_regfile_pkg;

  localparam logic [2:0] SZ_BYTE = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;
  localparam logic [2:0] SZ_LONG = 3'b100;

  // Widest register the helper supports; callers zero-extend and truncate.
  localparam int MAX_W = 128;

  typedef enum logic {CLEAR, RUN} rf_state_e;

  function automatic logic [MAX_W-1:0] merge_size(input logic [MAX_W-1:0] old_v,
                                                  input logic [MAX_W-1:0] new_v,
                                                  input logic [2:0]       size);
    logic [MAX_W-1:0] res;
    res = old_v;
    if (size[0])      res = {old_v[MAX_W-1:8],  new_v[7:0]};
    else if (size[1]) res = {old_v[MAX_W-1:16], new_v[15:0]};
    else if (size[2]) res = new_v;
    return res;
  endfunction

endpackage

// File: rtl/ao_register_file_if.sv
// Sequencer <-> register file port bundle: Dn/An read/write ports, USP access.
interface ao_register_file_if #(
  parameter int DATA_W = 32,
  parameter int NUM_DN = 8,
  parameter int NUM_AN = 8
);
  localparam int DN_AW = $clog2(NUM_DN);
  localparam int AN_AW = $clog2(NUM_AN);

  logic              supervisor;
  logic              busy;
  logic [DN_AW-1:0]  dn_rd_addr;
  logic [DATA_W-1:0] dn_rd_data;
  logic              dn_wr_en;
  logic [DN_AW-1:0]  dn_wr_addr;
  logic [DATA_W-1:0] dn_wr_data;
  logic [2:0]        dn_wr_size;
  logic [AN_AW-1:0]  an_rd_addr;
  logic [DATA_W-1:0] an_rd_data;
  logic              an_wr_en;
  logic [AN_AW-1:0]  an_wr_addr;
  logic [DATA_W-1:0] an_wr_data;
  logic [2:0]        an_wr_size;
  logic              usp_wr_en;
  logic [DATA_W-1:0] usp_wr_data;
  logic [DATA_W-1:0] usp;

  modport master (
    output supervisor, dn_rd_addr, dn_wr_en, dn_wr_addr, dn_wr_data, dn_wr_size,
           an_rd_addr, an_wr_en, an_wr_addr, an_wr_data, an_wr_size,
           usp_wr_en, usp_wr_data,
    input  busy, dn_rd_data, an_rd_data, usp
  );

  modport slave (
    input  supervisor, dn_rd_addr, dn_wr_en, dn_wr_addr, dn_wr_data, dn_wr_size,
           an_rd_addr, an_wr_en, an_wr_addr, an_wr_data, an_wr_size,
           usp_wr_en, usp_wr_data,
    output busy, dn_rd_data, an_rd_data, usp
  );

endinterface

// File: rtl/ao_register_file_bank.sv
// Generic DEPTH x DATA_W register array: size-merged writes, registered read,
// write-first bypass when reading the entry being written.
module ao_regfile_bank
  import ao68000_regfile_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int AW     = 3
) (
  input  logic              i_clk,
  input  logic [AW-1:0]     i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_wr_en,
  input  logic [AW-1:0]     i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [2:0]        i_wr_size
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rd_data;
  logic              w_rd_ok, w_wr_ok;
  logic [DATA_W-1:0] w_old, w_merged, w_rd_raw;

  // Addresses past DEPTH can arrive (An index aliased to the SP); treat as empty.
  assign w_rd_ok  = {1'b0, i_rd_addr} < (AW+1)'(DEPTH);
  assign w_wr_ok  = {1'b0, i_wr_addr} < (AW+1)'(DEPTH);
  assign w_old    = w_wr_ok ? r_mem[i_wr_addr] : '0;
  assign w_rd_raw = w_rd_ok ? r_mem[i_rd_addr] : '0;
  assign w_merged = DATA_W'(merge_size(MAX_W'(w_old), MAX_W'(i_wr_data), i_wr_size));

  always_ff @(posedge i_clk) begin
    if (i_wr_en && w_wr_ok) r_mem[i_wr_addr] <= w_merged;
    if (i_wr_en && w_wr_ok && i_wr_addr == i_rd_addr) r_rd_data <= w_merged;
    else                                              r_rd_data <= w_rd_raw;
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/ao_register_file.sv
// ao68000 Dn/An register file: two array banks, banked USP/SSP flops for the
// top An index, and a post-reset zero-fill sweep.
module ao_register_file
  import ao68000_regfile_pkg::*;
#(
  parameter int              DATA_W         = 32,
  parameter int              NUM_DN         = 8,
  parameter int              NUM_AN         = 8,
  parameter logic [DATA_W-1:0] SSP_INIT     = '0,
  parameter bit              CLEAR_ON_RESET = 1'b1
) (
  input logic clock,
  input logic reset,
  ao_register_file_if.slave rf
);

  localparam int DN_AW   = $clog2(NUM_DN);
  localparam int AN_AW   = $clog2(NUM_AN);
  localparam int SWEEP_N = (NUM_DN > NUM_AN-1) ? NUM_DN : NUM_AN-1;
  localparam int SW_W    = (SWEEP_N > 1) ? $clog2(SWEEP_N) : 1;
  localparam logic [AN_AW-1:0] SP_IDX = AN_AW'(NUM_AN-1);

  rf_state_e         r_state;
  logic [SW_W-1:0]   r_idx;
  logic [DATA_W-1:0] r_usp, r_ssp, r_sp_rd;
  logic              r_an_rd_sp;

  logic              w_busy, w_run, w_clr;
  logic              w_dn_we, w_an_we, w_sp_wr;
  logic [DN_AW-1:0]  w_dn_waddr;
  logic [AN_AW-1:0]  w_an_waddr;
  logic [DATA_W-1:0] w_dn_wdata, w_an_wd, w_an_wdata;
  logic [2:0]        w_dn_wsize;
  logic [DATA_W-1:0] w_usp_next, w_ssp_next;
  logic [DATA_W-1:0] w_dn_bank_rd, w_an_bank_rd;

  assign w_busy = (r_state == CLEAR);
  assign w_run  = !w_busy && !reset;
  assign w_clr  = w_busy && CLEAR_ON_RESET && !reset;

  // Word writes to An are sign-extended; every other size writes the full word.
  assign w_an_wd = (rf.an_wr_size == SZ_WORD) ? DATA_W'($signed(rf.an_wr_data[15:0]))
                                              : rf.an_wr_data;
  assign w_sp_wr = w_run && rf.an_wr_en && (rf.an_wr_addr == SP_IDX);

  assign w_dn_we    = w_run ? rf.dn_wr_en
                            : (w_clr && ({1'b0, r_idx} < (SW_W+1)'(NUM_DN)));
  assign w_dn_waddr = w_run ? rf.dn_wr_addr : DN_AW'(r_idx);
  assign w_dn_wdata = w_run ? rf.dn_wr_data : '0;
  assign w_dn_wsize = w_run ? rf.dn_wr_size : SZ_LONG;

  assign w_an_we    = w_run ? (rf.an_wr_en && rf.an_wr_addr != SP_IDX)
                            : (w_clr && ({1'b0, r_idx} < (SW_W+1)'(NUM_AN-1)));
  assign w_an_waddr = w_run ? rf.an_wr_addr : AN_AW'(r_idx);
  assign w_an_wdata = w_run ? w_an_wd : '0;

  // An write to the user SP outranks the explicit USP write in the same cycle.
  always_comb begin
    w_usp_next = r_usp;
    w_ssp_next = r_ssp;
    if (w_sp_wr && rf.supervisor)        w_ssp_next = w_an_wd;
    if (w_sp_wr && !rf.supervisor)       w_usp_next = w_an_wd;
    else if (w_run && rf.usp_wr_en)      w_usp_next = rf.usp_wr_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= CLEAR;
      r_idx      <= '0;
      r_usp      <= '0;
      r_ssp      <= SSP_INIT;
      r_sp_rd    <= '0;
      r_an_rd_sp <= 1'b0;
    end else begin
      if (r_state == CLEAR) begin
        if (!CLEAR_ON_RESET || r_idx == SW_W'(SWEEP_N-1)) r_state <= RUN;
        r_idx <= r_idx + 1'b1;
      end
      r_usp      <= w_usp_next;
      r_ssp      <= w_ssp_next;
      r_sp_rd    <= rf.supervisor ? w_ssp_next : w_usp_next;
      r_an_rd_sp <= (rf.an_rd_addr == SP_IDX);
    end
  end

  ao_regfile_bank #(.DEPTH(NUM_DN), .DATA_W(DATA_W), .AW(DN_AW)) u_dn_bank (
    .i_clk     (clock),
    .i_rd_addr (rf.dn_rd_addr),
    .o_rd_data (w_dn_bank_rd),
    .i_wr_en   (w_dn_we),
    .i_wr_addr (w_dn_waddr),
    .i_wr_data (w_dn_wdata),
    .i_wr_size (w_dn_wsize)
  );

  ao_regfile_bank #(.DEPTH(NUM_AN-1), .DATA_W(DATA_W), .AW(AN_AW)) u_an_bank (
    .i_clk     (clock),
    .i_rd_addr (rf.an_rd_addr),
    .o_rd_data (w_an_bank_rd),
    .i_wr_en   (w_an_we),
    .i_wr_addr (w_an_waddr),
    .i_wr_data (w_an_wdata),
    .i_wr_size (SZ_LONG)
  );

  assign rf.busy       = w_busy;
  assign rf.usp        = r_usp;
  assign rf.dn_rd_data = w_busy ? '0 : w_dn_bank_rd;
  assign rf.an_rd_data = w_busy ? '0 : (r_an_rd_sp ? r_sp_rd : w_an_bank_rd);

endmodule
